dsc_s2b: RTL
============

DSC_S2B -- requirements
Module: dsc_s2b

Interface
REQ-001 Parameter WIDTH, default 32, is the width of the binary result accumulator z.
REQ-002 Parameter LEN_WIDTH, default 32, is the width of the frame-length input len.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  global enable; low freezes all state, including handshake completion.
REQ-006 start  input  1  request to begin a new frame; len is sampled with it.
REQ-007 len  input  LEN_WIDTH  number of stream bits in the frame.
REQ-008 sn_in  input  1  stochastic bitstream bit.
REQ-009 sn_valid  input  1  sn_in qualifier; a bit is consumed only when sn_valid=1 and en=1 in ACC.
REQ-010 z  output  WIDTH  count of ones in the completed frame, held while z_valid=1.
REQ-011 z_valid  output  1  result-available flag.
REQ-012 z_ready  input  1  consumer accept; the handshake completes on a rising edge where z_valid=1, z_ready=1 and en=1.
REQ-013 busy  output  1  high in ACC and DONE.
REQ-014 ov  output  1  sticky per-frame flag; set when the accumulator saturates.

Function
REQ-015 The block SHALL implement three states:
- IDLE: waiting for start.
- ACC: accumulating stream bits.
- DONE: holding the result for the consumer.

REQ-016 IDLE transitions:
- On start=1 and en=1 with len!=0: load remaining=len, clear acc and ov, go to ACC.
- On start=1 and en=1 with len=0: load z=0 and ov=0, go directly to DONE, so z_valid is high the cycle after start.

REQ-017 In ACC, each consumed bit SHALL:
- decrement remaining;
- add sn_in to acc with saturation at 2^WIDTH-1;
- set ov on the first increment attempted while acc is at its maximum.

REQ-018 When the consumed bit has remaining=1, the same edge SHALL load z with the final count (including that bit) and enter DONE; z_valid SHALL be high the following cycle (one cycle of latency after the last bit).

REQ-019 Cycles in ACC with sn_valid=0 or en=0 SHALL leave acc, remaining and ov unchanged.

REQ-020 start SHALL be ignored in ACC; the frame in flight is never restarted except by reset.

REQ-021 DONE behaviour:
- z, ov and z_valid SHALL remain stable until the handshake completes.
- On handshake completion, go to IDLE and clear z_valid the next cycle.
- z retains its last value until the next frame loads it.

REQ-022 If start=1 on the handshake-completion edge in DONE, the block SHALL complete the handshake and start the new frame on the same edge (DONE->ACC, or DONE->DONE for len=0) with no idle cycle.

REQ-023 start in DONE without handshake completion SHALL be ignored.

REQ-024 sn_in and sn_valid SHALL be ignored outside ACC.

REQ-025 Width rules:
- acc and z are WIDTH bits.
- remaining is LEN_WIDTH bits and never decrements below 1 while in ACC.
- A frame with len > 2^WIDTH-1 ones saturates z at 2^WIDTH-1 with ov=1; there is no wrap-around.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, z=0, z_valid=0, busy=0, ov=0, acc=0, remaining=0, regardless of clk or en.

REQ-027 Reset asserted mid-frame or in DONE SHALL discard the partial or held result; no z_valid pulse SHALL follow reset release.

REQ-028 After rst returns high, the block SHALL accept start on the first rising edge.

Verification
REQ-029 len=16, sn_in=1, sn_valid=1 for 16 cycles -> z=16, z_valid high one cycle after the 16th bit, ov=0; with z_ready=1, busy=0 the next cycle.

REQ-030 len=8, bits 1,0,1,1,0,0,1,0 with sn_valid gapped every other cycle and en=0 for 3 cycles mid-frame -> z=4, ov=0, remaining frozen during the gaps.

REQ-031 WIDTH=4, len=20, all ones -> z=15, ov=1, z_valid after the 20th bit.

REQ-032 len=0 start -> z=0, z_valid high the next cycle, ov=0.

REQ-033 Back-to-back frames:
- Stimulus: hold z_ready=0 for 5 cycles in DONE (z=7, len 7 all ones), then z_ready=1 together with start=1, len=3, 3 ones.
- Response: z stable at 7 throughout; next result z=3 with no IDLE cycle between frames.

REQ-034 Reset mid-frame:
- Stimulus: rst=0 after 5 of len=10 bits, then release and run a len=4 all-ones frame.
- Response: all outputs 0 during reset; second frame gives z=4, ov=0.

Source files
------------

// File: rtl/dsc_s2b.sv
// dsc_s2b: stochastic bitstream to binary converter, counts ones over a len-bit frame with a valid/ready result
module dsc_s2b #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 sn_in,
  input  logic                 sn_valid,
  output logic [WIDTH-1:0]     z,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 busy,
  output logic                 ov
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [LEN_WIDTH-1:0] rem;
  logic hs, go, take, last, sat;
  always_comb begin
    hs     = en && state == DONE && z_ready;
    go     = en && start && (state == IDLE || hs);
    take   = en && state == ACC && sn_valid;
    last   = take && rem == LEN_WIDTH'(1);
    sat    = &acc;
    acc_nx = (sn_in && !sat) ? acc + WIDTH'(1) : acc;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // a start on the handshake edge chains straight into the next frame
  always_comb
    state_nx = go ? ((len == '0) ? DONE : ACC) : last ? DONE : hs ? IDLE : state;
  always_comb begin
    busy    = state != IDLE;
    z_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      rem <= '0;
      z   <= '0;
      ov  <= 1'b0;
    end else if (go) begin
      acc <= '0;
      rem <= len;
      ov  <= 1'b0;
      if (len == '0) z <= '0;
    end else if (take) begin
      acc <= acc_nx;
      rem <= rem - LEN_WIDTH'(1);
      ov  <= ov | (sn_in & sat);
      if (last) z <= acc_nx;
    end
endmodule
